// File: rtl/gpio_modport_pkg.sv
// Shared constants and types for the 32-pin GPIO controller.
package gpio_pkg;

    localparam int NPINS = 32;
    localparam int NCFG  = 6;

    localparam logic [11:0] GPIO_PADDIR    = 12'h000;
    localparam logic [11:0] GPIO_PADIN     = 12'h004;
    localparam logic [11:0] GPIO_PADOUT    = 12'h008;
    localparam logic [11:0] GPIO_INTEN     = 12'h00C;
    localparam logic [11:0] GPIO_INTTYPE0  = 12'h010;
    localparam logic [11:0] GPIO_INTTYPE1  = 12'h014;
    localparam logic [11:0] GPIO_INTSTATUS = 12'h018;
    localparam logic [11:0] GPIO_PADCFG0   = 12'h020;

    // Encoding is {INTTYPE1[i], INTTYPE0[i]}
    typedef enum logic [1:0] {
        LVL_HI = 2'b00,
        LVL_LO = 2'b01,
        RISE   = 2'b10,
        FALL   = 2'b11
    } int_type_e;

endpackage

// File: rtl/gpio_modport_if.sv
// APB bus bundle between the SoC peripheral bus and the GPIO register slave.
interface gpio_modport_if;

    logic [11:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/gpio_modport_int_detect.sv
// Input synchroniser, previous-value register and sticky interrupt status for all pins.
module gpio_int_detect
    import gpio_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [NPINS-1:0] gpio_in,
    input  logic [NPINS-1:0] inten,
    input  logic [NPINS-1:0] inttype0,
    input  logic [NPINS-1:0] inttype1,
    input  logic             status_clr,
    output logic [NPINS-1:0] padin,
    output logic [NPINS-1:0] intstatus
);

    logic [NPINS-1:0] sync1;
    logic [NPINS-1:0] prev;
    logic [NPINS-1:0] cond;

    always_comb begin
        cond = '0;
        for (int unsigned i = 0; i < NPINS; i++) begin
            if (inten[i]) begin
                case (int_type_e'({inttype1[i], inttype0[i]}))
                    LVL_HI: cond[i] = padin[i];
                    LVL_LO: cond[i] = ~padin[i];
                    RISE:   cond[i] = padin[i] & ~prev[i];
                    FALL:   cond[i] = ~padin[i] & prev[i];
                endcase
            end
        end
    end

    // A condition true in the clearing cycle keeps its bit set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            padin     <= '0;
            prev      <= '0;
            intstatus <= '0;
        end else begin
            sync1     <= gpio_in;
            padin     <= sync1;
            prev      <= padin;
            intstatus <= (status_clr ? '0 : intstatus) | cond;
        end
    end

endmodule

// File: rtl/gpio_modport.sv
// 32-pin GPIO controller: APB register file, pad outputs/config and level interrupt.
module gpio_modport
    import gpio_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    gpio_modport_if.slave               apb,
    input  logic [NPINS-1:0]            gpio_in,
    output logic [NPINS-1:0]            gpio_out,
    output logic [NPINS-1:0]            gpio_dir,
    output logic [NCFG-1:0][NPINS-1:0]  gpio_padcfg,
    output logic                        interrupt
);

    logic [11:0]                 addr;
    logic                        wr_en;
    logic                        rd_en;
    logic                        status_clr;
    logic                        cfg_hit;
    logic [2:0]                  cfg_idx;
    logic [NPINS-1:0]            paddir;
    logic [NPINS-1:0]            padout;
    logic [NPINS-1:0]            inten;
    logic [NPINS-1:0]            inttype0;
    logic [NPINS-1:0]            inttype1;
    logic [NPINS-1:0]            padin;
    logic [NPINS-1:0]            intstatus;
    logic [NCFG-1:0][NPINS-1:0]  padcfg;

    assign addr       = {apb.paddr[11:2], 2'b00};
    assign wr_en      = apb.psel & apb.penable & apb.pwrite;
    assign rd_en      = apb.psel & apb.penable & ~apb.pwrite;
    assign status_clr = rd_en && (addr == GPIO_INTSTATUS);
    assign cfg_hit    = (addr >= GPIO_PADCFG0) && (addr < GPIO_PADCFG0 + 12'(4 * NCFG));
    assign cfg_idx    = 3'((addr - GPIO_PADCFG0) >> 2);

    assign apb.pready  = 1'b1;
    assign apb.pslverr = 1'b0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            paddir   <= '0;
            padout   <= '0;
            inten    <= '0;
            inttype0 <= '0;
            inttype1 <= '0;
            padcfg   <= '0;
        end else if (wr_en) begin
            case (addr)
                GPIO_PADDIR:   paddir   <= apb.pwdata;
                GPIO_PADOUT:   padout   <= apb.pwdata;
                GPIO_INTEN:    inten    <= apb.pwdata;
                GPIO_INTTYPE0: inttype0 <= apb.pwdata;
                GPIO_INTTYPE1: inttype1 <= apb.pwdata;
                default: begin
                    if (cfg_hit) padcfg[cfg_idx] <= apb.pwdata;
                end
            endcase
        end
    end

    always_comb begin
        apb.prdata = '0;
        if (rd_en) begin
            case (addr)
                GPIO_PADDIR:    apb.prdata = paddir;
                GPIO_PADIN:     apb.prdata = padin;
                GPIO_PADOUT:    apb.prdata = padout;
                GPIO_INTEN:     apb.prdata = inten;
                GPIO_INTTYPE0:  apb.prdata = inttype0;
                GPIO_INTTYPE1:  apb.prdata = inttype1;
                GPIO_INTSTATUS: apb.prdata = intstatus;
                default: begin
                    if (cfg_hit) apb.prdata = padcfg[cfg_idx];
                end
            endcase
        end
    end

    gpio_int_detect u_int_detect (
        .clock      (clock),
        .reset      (reset),
        .gpio_in    (gpio_in),
        .inten      (inten),
        .inttype0   (inttype0),
        .inttype1   (inttype1),
        .status_clr (status_clr),
        .padin      (padin),
        .intstatus  (intstatus)
    );

    assign gpio_out    = padout;
    assign gpio_dir    = paddir;
    assign gpio_padcfg = padcfg;
    assign interrupt   = |intstatus;

endmodule

// File: tb/tb_gpio_modport.sv
// Directed bench for gpio_modport with a register/pin-history reference model.
module tb_gpio_modport;
    import gpio_pkg::*;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic [31:0]                 gpio_in = '0;
    logic [31:0]                 gpio_out;
    logic [31:0]                 gpio_dir;
    logic [5:0][31:0]            gpio_padcfg;
    logic                        interrupt;

    int checks   = 0;
    int failures = 0;

    gpio_modport_if apb();

    gpio_modport dut (
        .clock       (clock),
        .reset       (reset),
        .apb         (apb),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_dir    (gpio_dir),
        .gpio_padcfg (gpio_padcfg),
        .interrupt   (interrupt)
    );

    always #5 clock = ~clock;

    // Reference model: register values plus the pin samples taken at the last three edges
    logic [31:0]      m_dir = '0, m_out = '0, m_en = '0, m_t0 = '0, m_t1 = '0, m_status = '0;
    logic [5:0][31:0] m_cfg = '0;
    logic [31:0]      hist [3] = '{default: '0};

    function automatic logic [31:0] model_read(input logic [11:0] a_in);
        logic [11:0] a;
        a = {a_in[11:2], 2'b00};
        case (a)
            12'h000: return m_dir;
            12'h004: return hist[1];
            12'h008: return m_out;
            12'h00C: return m_en;
            12'h010: return m_t0;
            12'h014: return m_t1;
            12'h018: return m_status;
            12'h020, 12'h024, 12'h028, 12'h02C, 12'h030, 12'h034:
                return m_cfg[(a - 12'h020) >> 2];
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] model_cond();
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            if (m_en[i]) begin
                case ({m_t1[i], m_t0[i]})
                    2'b00: c[i] = hist[1][i];
                    2'b01: c[i] = !hist[1][i];
                    2'b10: c[i] = hist[1][i] && !hist[2][i];
                    default: c[i] = !hist[1][i] && hist[2][i];
                endcase
            end
        end
        return c;
    endfunction

    always @(posedge clock or negedge reset) begin : model
        logic [31:0] c;
        logic [11:0] a;
        if (!reset) begin
            m_dir = '0; m_out = '0; m_en = '0; m_t0 = '0; m_t1 = '0; m_status = '0;
            m_cfg = '0;
            hist[0] = '0; hist[1] = '0; hist[2] = '0;
        end else begin
            c = model_cond();
            a = {apb.paddr[11:2], 2'b00};
            if (apb.psel && apb.penable && !apb.pwrite && a == 12'h018) m_status = '0;
            m_status = m_status | c;
            if (apb.psel && apb.penable && apb.pwrite) begin
                case (a)
                    12'h000: m_dir = apb.pwdata;
                    12'h008: m_out = apb.pwdata;
                    12'h00C: m_en  = apb.pwdata;
                    12'h010: m_t0  = apb.pwdata;
                    12'h014: m_t1  = apb.pwdata;
                    12'h020, 12'h024, 12'h028, 12'h02C, 12'h030, 12'h034:
                        m_cfg[(a - 12'h020) >> 2] = apb.pwdata;
                    default: ;
                endcase
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = gpio_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at negedge+1; outputs are compared at negedge+3, well clear of the posedge
    always @(negedge clock) begin
        #3;
        chk("model_gpio_out", gpio_out, m_out);
        chk("model_gpio_dir", gpio_dir, m_dir);
        for (int k = 0; k < 6; k++) chk("model_padcfg", gpio_padcfg[k], m_cfg[k]);
        chk("model_interrupt", 32'(interrupt), 32'(|m_status));
        if (apb.psel && apb.penable && !apb.pwrite)
            chk("model_prdata", apb.prdata, model_read(apb.paddr));
    end

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clock); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = a; apb.pwdata = d;
        @(negedge clock); #1;
        apb.penable = 1'b1;
        @(negedge clock); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge clock); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
        @(negedge clock); #1;
        apb.penable = 1'b1;
        #2 d = apb.prdata;
        @(negedge clock); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    logic [31:0] d;
    logic [31:0] vals [4] = '{32'hFFFF_FFFF, 32'h0, 32'h5A5A_5A5A, 32'h0};

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;

        for (int k = 0; k < 14; k++) begin
            apb_read(12'(k * 4), d);
            chk("reset_read", d, 32'h0);
        end

        apb_write(GPIO_PADDIR, 32'hF0F0_0F0F);
        chk("dir_after_write", gpio_dir, 32'hF0F0_0F0F);
        apb_write(GPIO_PADOUT, 32'h1234_5678);
        chk("out_after_write", gpio_out, 32'h1234_5678);
        apb_read(GPIO_PADDIR, d); chk("dir_readback", d, 32'hF0F0_0F0F);
        apb_read(GPIO_PADOUT, d); chk("out_readback", d, 32'h1234_5678);

        apb_write(12'h02C, 32'hAAAA_5555);
        for (int k = 0; k < 6; k++)
            chk("padcfg_rows", gpio_padcfg[k], (k == 3) ? 32'hAAAA_5555 : 32'h0);
        apb_read(12'h02C, d); chk("padcfg3_readback", d, 32'hAAAA_5555);

        // Hold a PADIN read in access phase across the input change
        @(negedge clock); #1;
        gpio_in = 32'hDEAD_BEEF;
        apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = 1'b0; apb.paddr = GPIO_PADIN;
        #2 chk("padin_before_edge", apb.prdata, 32'h0);
        @(negedge clock); #3 chk("padin_first_cycle", apb.prdata, 32'h0);
        @(negedge clock); #3 chk("padin_second_cycle", apb.prdata, 32'hDEAD_BEEF);
        @(negedge clock); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;

        @(negedge clock); #1 gpio_in = '0;
        repeat (3) @(negedge clock);
        apb_write(GPIO_INTTYPE1, 32'h0000_0020);
        apb_write(GPIO_INTTYPE0, 32'h0);
        apb_write(GPIO_INTEN,    32'h0000_0020);
        @(negedge clock); #1 gpio_in[5] = 1'b1;
        @(negedge clock); #3 chk("rise_edge_n1", 32'(interrupt), 32'h0);
        @(negedge clock); #3 chk("rise_edge_n2_pre", 32'(interrupt), 32'h0);
        @(negedge clock); #3 chk("rise_edge_n2", 32'(interrupt), 32'h1);
        apb_read(GPIO_INTSTATUS, d); chk("rise_status", d, 32'h0000_0020);
        chk("rise_cleared", 32'(interrupt), 32'h0);
        apb_read(GPIO_INTSTATUS, d); chk("rise_second_read", d, 32'h0);

        apb_write(GPIO_INTEN, 32'h0);
        @(negedge clock); #1 gpio_in = '0;
        apb_write(GPIO_INTTYPE1, 32'h0);
        apb_write(GPIO_INTTYPE0, 32'h0000_0001);
        apb_write(GPIO_INTEN,    32'h0000_0001);
        repeat (3) @(negedge clock);
        apb_read(GPIO_INTSTATUS, d); chk("lvl_lo_status", d, 32'h1);
        chk("lvl_lo_set_wins", 32'(interrupt), 32'h1);
        @(negedge clock); #1 gpio_in[0] = 1'b1;
        apb_read(GPIO_INTSTATUS, d); chk("lvl_lo_last_read", d, 32'h1);
        for (int c = 0; c < 3 && interrupt; c++) @(negedge clock);
        chk("lvl_lo_clear", 32'(interrupt), 32'h0);

        apb_write(GPIO_INTEN, 32'h0);
        apb_read(GPIO_INTSTATUS, d);
        for (int v = 0; v < 4; v++) begin
            @(negedge clock); #1 gpio_in = vals[v];
            repeat (3) @(negedge clock);
            #3 chk("disabled_no_irq", 32'(interrupt), 32'h0);
        end

        apb_write(GPIO_PADIN,     32'hFFFF_FFFF);
        apb_write(GPIO_INTSTATUS, 32'hFFFF_FFFF);
        apb_write(12'h040,        32'hFFFF_FFFF);
        apb_read(GPIO_PADDIR, d);    chk("ro_dir",     d, 32'hF0F0_0F0F);
        apb_read(GPIO_PADOUT, d);    chk("ro_out",     d, 32'h1234_5678);
        apb_read(GPIO_INTEN, d);     chk("ro_inten",   d, 32'h0);
        apb_read(GPIO_INTTYPE0, d);  chk("ro_type0",   d, 32'h1);
        apb_read(GPIO_INTTYPE1, d);  chk("ro_type1",   d, 32'h0);
        apb_read(GPIO_PADIN, d);     chk("ro_padin",   d, 32'h0);
        apb_read(GPIO_INTSTATUS, d); chk("ro_status",  d, 32'h0);
        apb_read(12'h02C, d);        chk("ro_padcfg3", d, 32'hAAAA_5555);
        apb_read(12'h040, d);        chk("unmapped_read", d, 32'h0);

        // Reset asserted in the middle of a write access phase
        @(negedge clock); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = GPIO_PADOUT;
        apb.pwdata = 32'hCAFE_F00D;
        @(negedge clock); #1 apb.penable = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_out",    gpio_out, 32'h0);
        chk("rst_mid_dir",    gpio_dir, 32'h0);
        chk("rst_mid_cfg3",   gpio_padcfg[3], 32'h0);
        chk("rst_mid_irq",    32'(interrupt), 32'h0);
        chk("rst_mid_prdata", apb.prdata, 32'h0);
        @(negedge clock); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        @(negedge clock); #1 reset = 1'b1;
        apb_read(GPIO_PADOUT, d); chk("rst_padout", d, 32'h0);
        apb_read(12'h02C, d);     chk("rst_padcfg3", d, 32'h0);

        repeat (2) @(negedge clock);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/gpio_modport.md
# gpio_modport

32-pin general-purpose I/O controller with an APB register slave. It drives pad output values, direction and six bits of pad configuration per pin, and synchronises pad inputs. It raises a single level interrupt from per-pin edge- or level-sensitive detectors. It sits between the SoC peripheral APB bus and the pad ring.

## Interface
- `NPINS`, 32: number of GPIO pins; fixed at 32 in this revision.
- `NCFG`, 6: pad-config bits per pin.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `paddr`  in  12: APB byte address; bits [1:0] are ignored.
- `psel`, `penable`, `pwrite`  in  1 each: APB control.
- `pwdata`  in  32: APB write data.
- `prdata`  out  32: APB read data.
- `pready`  out  1: tied to 1, so there are no wait states.
- `pslverr`  out  1: tied to 0.
- `gpio_in`  in  32: asynchronous pad inputs.
- `gpio_out`  out  32: pad output values, equal to PADOUT.
- `gpio_dir`  out  32: pad direction, equal to PADDIR; 1 = output.
- `gpio_padcfg`  out  [5:0][31:0]: `gpio_padcfg[k]` = PADCFGk.
- `interrupt`  out  1: OR of INTSTATUS.

## Operation
Register map (offsets):
- 0x00 PADDIR: RW.
- 0x04 PADIN: RO, synchronised inputs.
- 0x08 PADOUT: RW.
- 0x0C INTEN: RW.
- 0x10 INTTYPE0: RW.
- 0x14 INTTYPE1: RW.
- 0x18 INTSTATUS: RO, clear-on-read.
- 0x20 + 4k, k = 0..5: PADCFGk, RW.

Bus rules:
- Unmapped reads return 0.
- Writes to RO or unmapped addresses are ignored.

Input path:
- Two-flop synchroniser per pin; the second stage is PADIN.
- A third register `prev` holds the previous PADIN value.

Interrupt condition for pin i when INTEN[i] = 1, selected by {INTTYPE1[i], INTTYPE0[i]}:
- 00: level high, PADIN[i] = 1.
- 01: level low, PADIN[i] = 0.
- 10: rising edge, PADIN[i] & ~prev[i].
- 11: falling edge, ~PADIN[i] & prev[i].

INTSTATUS behaviour:
- INTSTATUS[i] is sticky and is set by its condition.
- An APB read of INTSTATUS returns the current value and clears all bits in the same access.
- If a condition is true in the clearing cycle, that bit stays set (set wins over clear).
- Level conditions therefore re-set the bit every cycle while the level holds.
- Clearing INTEN[i] does not clear INTSTATUS[i].
- `interrupt` = |INTSTATUS, combinational from the register.

Reset:
- All registers reset to 0, as do the synchroniser and `prev`.
- All outputs are therefore 0 after reset.

## Timing
APB accesses:
- Write: committed at the rising edge where psel & penable & pwrite. The output ports reflect the new value immediately after that edge.
- Read: `prdata` is combinational during the access phase (psel & penable & ~pwrite).
- INTSTATUS clear: takes effect at the end of the access-phase edge.

Input latency, for `gpio_in` changing before edge N:
- Captured at edge N; PADIN is valid after edge N+1.
- Edge-type INTSTATUS and `interrupt` are set after edge N+2.
- Level-type status is also set after edge N+2.

Other timing rules:
- Pulses shorter than one clock may be missed; the spec requires no capture of them.
- Reset asserted mid-access: all state clears immediately; the access is lost.

## Structure
- Shared package `gpio_pkg`:
  - register offset constants: `GPIO_PADDIR` … `GPIO_PADCFG0`;
  - `NPINS`, `NCFG`;
  - interrupt-type enum: `LVL_HI`, `LVL_LO`, `RISE`, `FALL`.
- One natural sub-module `gpio_int_detect`: synchroniser, `prev`, condition logic, and the INTSTATUS set/clear for all 32 pins.

## Test plan
- Reset: assert `reset` = 0 mid-operation → all outputs, `prdata` and `interrupt` are 0. Read every register → 0.
- Register RW:
  - Write PADDIR = 0xF0F0_0F0F and PADOUT = 0x1234_5678 → `gpio_dir` and `gpio_out` equal these values the cycle after the write; readback matches.
  - Write PADCFG3 = 0xAAAA_5555 → `gpio_padcfg[3]` = 0xAAAA_5555, other rows unchanged.
- Input sync: drive `gpio_in` = 0xDEAD_BEEF → PADIN read returns 0xDEAD_BEEF from the second cycle after the change; the first cycle still shows the old value.
- Rising edge:
  - Setup: INTEN[5] = 1, type RISE. Drive `gpio_in[5]` 0→1.
  - → `interrupt` = 1 two edges after capture.
  - Reading INTSTATUS → 0x0000_0020, then `interrupt` = 0. A second read → 0.
- Level low:
  - Setup: INTEN[0] = 1, type LVL_LO, pin held at 0.
  - → a read of INTSTATUS returns 0x1 and `interrupt` stays 1 (set wins).
  - Driving the pin to 1 and reading again clears `interrupt` within 3 cycles.
- Disabled and unmapped:
  - INTEN = 0 with pin toggles → `interrupt` stays 0.
  - Write to 0x04, 0x18 and 0x40 → no state change; reading 0x40 → 0.
